controlador_umidade: RTL and testbench

Sequencer for the 8-bit sensor adder in the Umni humidity path. Periodically requests one reading pair from the two humidity sensors (0..100, 7 bits each) over a 4-phase handshake, and range-checks both values. Drives the external adder to average them, then runs hysteresis control of the irrigation pump with a minimum on-time. Adder stays combinational and outside this block; this block owns its inputs and samples its result.

---
 rtl/controlador_umidade.sv | 233 +++++++++++++++++++++++
 tb/tb_controlador_umidade.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/controlador_umidade.sv
// controlador_umidade: sequencer for the Umni humidity path.
// Periodically requests a reading pair from two humidity sensors over a 4-phase
// handshake and range-checks both values. It feeds the external combinational
// adder, registers the sum and publishes the truncated (or rounded) average. It
// then runs hysteresis control of the irrigation pump with a minimum on-time.
//
// Optional feature: define ARREDONDA_EN to drive somador_cin=1, which gives a
// round-half-up average instead of truncation.
//
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   habilita              controller enable; low forces OCIOSO and pump off
//   sensor_req/ack        4-phase request/acknowledge to the sensor pair
//   sensor1/sensor2       7-bit readings, valid while sensor_ack is high
//   somador_a/b/cin       operands and carry-in of the external adder
//   somador_resultado     8-bit sum returned by the adder
//   media/media_valida    last valid average and its one-cycle update pulse
//   bomba                 pump drive
//   erro                  sensor fault flag (timeout or out-of-range reading)
module controlador_umidade #(
  parameter int unsigned PERIODO_AMOSTRA = 1000,
  parameter int unsigned TIMEOUT_ACK     = 16,
  parameter int unsigned LIMIAR_LIGA     = 40,
  parameter int unsigned LIMIAR_DESLIGA  = 60,
  parameter int unsigned TEMPO_MIN_BOMBA = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       habilita,
  output logic       sensor_req,
  input  logic       sensor_ack,
  input  logic [6:0] sensor1,
  input  logic [6:0] sensor2,
  output logic [6:0] somador_a,
  output logic [6:0] somador_b,
  output logic       somador_cin,
  input  logic [7:0] somador_resultado,
  output logic [6:0] media,
  output logic       media_valida,
  output logic       bomba,
  output logic       erro
);

  localparam int unsigned W_DADO = 7;
  localparam int unsigned W_PER  = $clog2(PERIODO_AMOSTRA + 1);
  localparam int unsigned W_TO   = $clog2(TIMEOUT_ACK + 1);
  localparam int unsigned W_ON   = $clog2(TEMPO_MIN_BOMBA + 1);

  localparam logic [W_PER-1:0]  PER_FIM    = W_PER'(PERIODO_AMOSTRA - 1);
  localparam logic [W_TO-1:0]   TO_FIM     = W_TO'(TIMEOUT_ACK - 1);
  localparam logic [W_ON-1:0]   ON_MIN     = W_ON'(TEMPO_MIN_BOMBA);
  localparam logic [W_ON-1:0]   ON_MAX     = '1;
  localparam logic [W_DADO-1:0] LIGA       = W_DADO'(LIMIAR_LIGA);
  localparam logic [W_DADO-1:0] DESLIGA    = W_DADO'(LIMIAR_DESLIGA);
  localparam logic [W_DADO-1:0] MAX_VALIDO = W_DADO'(100);

`ifdef ARREDONDA_EN
  localparam logic CIN_VAL = 1'b1;
`else
  localparam logic CIN_VAL = 1'b0;
`endif

  typedef enum logic [2:0] {
    OCIOSO = 3'd0,
    ESPERA = 3'd1,
    PEDE   = 3'd2,
    LIBERA = 3'd3,
    SOMA   = 3'd4,
    DECIDE = 3'd5
  } estado_t;

  estado_t           estado_q, estado_d;
  logic [W_PER-1:0]  per_q, per_d;
  logic [W_TO-1:0]   to_q, to_d;
  logic [W_ON-1:0]   on_q, on_d, on_inc;
  logic [W_DADO-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic [W_DADO-1:0] res_q, res_d;
  logic [W_DADO-1:0] media_q, media_d;
  logic              mv_q, mv_d;
  logic              bomba_q, bomba_d;
  logic              erro_q, erro_d;
  logic              req_q, req_d;
  logic              cin_q, cin_d;

  // The sum LSB is discarded by the halving, so only bits [7:1] are stored.
  logic unused_lsb;
  assign unused_lsb = somador_resultado[0];

  // State and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q <= OCIOSO;
      per_q    <= '0;
      to_q     <= '0;
      on_q     <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      res_q    <= '0;
      media_q  <= '0;
      mv_q     <= 1'b0;
      bomba_q  <= 1'b0;
      erro_q   <= 1'b0;
      req_q    <= 1'b0;
      cin_q    <= 1'b0;
    end else begin
      estado_q <= estado_d;
      per_q    <= per_d;
      to_q     <= to_d;
      on_q     <= on_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      res_q    <= res_d;
      media_q  <= media_d;
      mv_q     <= mv_d;
      bomba_q  <= bomba_d;
      erro_q   <= erro_d;
      req_q    <= req_d;
      cin_q    <= cin_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    estado_d = estado_q;
    per_d    = per_q;
    to_d     = to_q;
    on_d     = on_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    res_d    = res_q;
    media_d  = media_q;
    mv_d     = 1'b0;
    bomba_d  = bomba_q;
    erro_d   = erro_q;
    req_d    = req_q;
    cin_d    = CIN_VAL;
    on_inc   = (on_q == ON_MAX) ? on_q : on_q + W_ON'(1);

    if (!habilita) begin
      // Disable wins everywhere; media and erro are deliberately kept.
      estado_d = OCIOSO;
      req_d    = 1'b0;
      bomba_d  = 1'b0;
      on_d     = '0;
    end else begin
      unique case (estado_q)
        OCIOSO: begin
          estado_d = ESPERA;
          per_d    = '0;
        end

        ESPERA: begin
          // Period elapsed: hold off the request until a stale ack has dropped.
          if (per_q == PER_FIM) begin
            if (!sensor_ack) begin
              estado_d = PEDE;
              req_d    = 1'b1;
              to_d     = '0;
            end
          end else begin
            per_d = per_q + W_PER'(1);
          end
        end

        PEDE: begin
          if (sensor_ack) begin
            op_a_d   = sensor1;
            op_b_d   = sensor2;
            req_d    = 1'b0;
            estado_d = LIBERA;
          end else if (to_q == TO_FIM) begin
            erro_d   = 1'b1;
            bomba_d  = 1'b0;
            on_d     = '0;
            req_d    = 1'b0;
            per_d    = '0;
            estado_d = ESPERA;
          end else begin
            to_d = to_q + W_TO'(1);
          end
        end

        LIBERA: begin
          if (!sensor_ack) estado_d = SOMA;
        end

        SOMA: begin
          res_d    = somador_resultado[7:1];
          estado_d = DECIDE;
        end

        DECIDE: begin
          estado_d = ESPERA;
          per_d    = '0;
          if (op_a_q > MAX_VALIDO || op_b_q > MAX_VALIDO) begin
            erro_d  = 1'b1;
            bomba_d = 1'b0;
            on_d    = '0;
          end else begin
            erro_d  = 1'b0;
            media_d = res_q;
            mv_d    = 1'b1;
            // Hysteresis: threshold equality holds the current pump state.
            if (!bomba_q) begin
              if (res_q < LIGA) begin
                bomba_d = 1'b1;
                on_d    = W_ON'(1);
              end
            end else begin
              on_d = on_inc;
              if (res_q > DESLIGA && on_inc >= ON_MIN) begin
                bomba_d = 1'b0;
                on_d    = '0;
              end
            end
          end
        end

        default: estado_d = OCIOSO;
      endcase
    end
  end

  assign sensor_req   = req_q;
  assign somador_a    = op_a_q;
  assign somador_b    = op_b_q;
  assign somador_cin  = cin_q;
  assign media        = media_q;
  assign media_valida = mv_q;
  assign bomba        = bomba_q;
  assign erro         = erro_q;

endmodule

// File: tb/tb_controlador_umidade.sv
// Scoreboard bench for controlador_umidade: stimulus pushes the expected
// (media, bomba, erro) for each valid sample; a negedge monitor pops on every
// media_valida pulse. Error, timeout, disable and reset cases are checked inline.
module tb_controlador_umidade;

  localparam int unsigned PER  = 4;
  localparam int unsigned TO   = 16;
  localparam int unsigned TMIN = 3;

`ifdef ARREDONDA_EN
  localparam logic [6:0] MEDIA_S1 = 7'd36;
`else
  localparam logic [6:0] MEDIA_S1 = 7'd35;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic       habilita;
  logic       sensor_req;
  logic       sensor_ack;
  logic [6:0] sensor1;
  logic [6:0] sensor2;
  logic [6:0] somador_a;
  logic [6:0] somador_b;
  logic       somador_cin;
  logic [7:0] somador_resultado;
  logic [6:0] media;
  logic       media_valida;
  logic       bomba;
  logic       erro;

  controlador_umidade #(
    .PERIODO_AMOSTRA(PER),
    .TIMEOUT_ACK    (TO),
    .LIMIAR_LIGA    (40),
    .LIMIAR_DESLIGA (60),
    .TEMPO_MIN_BOMBA(TMIN)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .habilita         (habilita),
    .sensor_req       (sensor_req),
    .sensor_ack       (sensor_ack),
    .sensor1          (sensor1),
    .sensor2          (sensor2),
    .somador_a        (somador_a),
    .somador_b        (somador_b),
    .somador_cin      (somador_cin),
    .somador_resultado(somador_resultado),
    .media            (media),
    .media_valida     (media_valida),
    .bomba            (bomba),
    .erro             (erro)
  );

  // External combinational adder.
  assign somador_resultado = 8'(somador_a) + 8'(somador_b) + 8'(somador_cin);

  always #5 clock = ~clock;

  typedef struct packed {
    logic [6:0] media;
    logic       bomba;
    logic       erro;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
    checks++;
    if (atual !== esperado) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nome, atual, esperado, $time);
    end
  endtask

  // Monitor: every media_valida pulse must match the oldest expected sample.
  always @(negedge clock) begin : monitor
    exp_t e;
    if (media_valida === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL media_valida_unexpected: got pulse media=%0d expected no pulse", media);
      end else begin
        e = exp_q.pop_front();
        check("media", 32'(media), 32'(e.media));
        check("bomba_amostra", 32'(bomba), 32'(e.bomba));
        check("erro_amostra", 32'(erro), 32'(e.erro));
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic espera_req();
    int n = 0;
    while (sensor_req !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check("req_wait", 32'(sensor_req), 32'd1);
  endtask

  // One handshake: ack raised after 'atraso' request cycles, held 'manter' edges.
  task automatic aperto(input logic [6:0] s1, input logic [6:0] s2, input int atraso, input int manter);
    espera_req();
    repeat (atraso) tick();
    sensor1    = s1;
    sensor2    = s2;
    sensor_ack = 1'b1;
    tick();
    check("req_drop", 32'(sensor_req), 32'd0);
    for (int i = 1; i < manter; i++) begin
      tick();
      check("req_while_ack", 32'(sensor_req), 32'd0);
    end
    sensor_ack = 1'b0;
  endtask

  task automatic amostra(input logic [6:0] s1, input logic [6:0] s2, input logic [6:0] m, input logic b);
    exp_t e;
    e.media = m;
    e.bomba = b;
    e.erro  = 1'b0;
    exp_q.push_back(e);
    aperto(s1, s2, 1, 1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin : estimulo
    int   n;
    exp_t e;
    reset      = 1'b1;
    habilita   = 1'b0;
    sensor_ack = 1'b0;
    sensor1    = '0;
    sensor2    = '0;
    #12;
    check("rst_req", 32'(sensor_req), 32'd0);
    check("rst_bomba", 32'(bomba), 32'd0);
    check("rst_media", 32'(media), 32'd0);

    @(posedge clock); #1;
    reset    = 1'b0;
    habilita = 1'b1;
    tick();                                  // OCIOSO -> ESPERA
    repeat (PER - 1) tick();
    check("req_before_period", 32'(sensor_req), 32'd0);
    tick();
    check("req_after_period", 32'(sensor_req), 32'd1);

    // First sample: ack after 2 cycles, result on 3rd edge after ack sample.
    e.media = MEDIA_S1; e.bomba = 1'b1; e.erro = 1'b0;
    exp_q.push_back(e);
    aperto(7'd30, 7'd41, 2, 1);
    tick();
    tick();
    check("mv_early", 32'(media_valida), 32'd0);
    tick();
    check("mv_latency", 32'(media_valida), 32'd1);
    check("media_latency", 32'(media), 32'(MEDIA_S1));
    tick();
    check("mv_single_pulse", 32'(media_valida), 32'd0);

    // Minimum on-time and threshold equality.
    amostra(7'd70, 7'd70, 7'd70, 1'b1);      // on-count 2 < 3: hold
    amostra(7'd70, 7'd70, 7'd70, 1'b0);      // on-count 3: off
    amostra(7'd40, 7'd40, 7'd40, 1'b0);      // == LIGA: stay off
    amostra(7'd20, 7'd20, 7'd20, 1'b1);      // on
    amostra(7'd60, 7'd60, 7'd60, 1'b1);
    amostra(7'd60, 7'd60, 7'd60, 1'b1);      // == DESLIGA: hold
    amostra(7'd70, 7'd70, 7'd70, 1'b0);
    amostra(7'd10, 7'd10, 7'd10, 1'b1);

    // Out-of-range reading.
    aperto(7'd101, 7'd50, 1, 1);
    tick(); tick(); tick();
    check("range_erro", 32'(erro), 32'd1);
    check("range_bomba", 32'(bomba), 32'd0);
    check("range_media_kept", 32'(media), 32'd10);
    amostra(7'd50, 7'd50, 7'd50, 1'b0);      // clears erro
    amostra(7'd20, 7'd20, 7'd20, 1'b1);

    // Ack timeout.
    espera_req();
    n = 0;
    while (sensor_req === 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check("timeout_cycles", 32'(n), 32'(TO));
    check("timeout_erro", 32'(erro), 32'd1);
    check("timeout_bomba", 32'(bomba), 32'd0);
    n = 0;
    while (sensor_req !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check("period_after_timeout", 32'(n), 32'(PER));
    amostra(7'd50, 7'd50, 7'd50, 1'b0);

    // Ack held for 5 edges.
    e.media = 7'd20; e.bomba = 1'b1; e.erro = 1'b0;
    exp_q.push_back(e);
    aperto(7'd20, 7'd20, 1, 5);

    // Disable while in LIBERA.
    espera_req();
    tick();
    sensor1 = 7'd30; sensor2 = 7'd30; sensor_ack = 1'b1;
    tick();                                  // -> LIBERA
    habilita = 1'b0;
    tick();                                  // -> OCIOSO
    check("dis_bomba", 32'(bomba), 32'd0);
    check("dis_req", 32'(sensor_req), 32'd0);
    check("dis_media_kept", 32'(media), 32'd20);
    check("dis_erro_kept", 32'(erro), 32'd0);
    sensor_ack = 1'b0;
    repeat (8) tick();
    check("dis_req_idle", 32'(sensor_req), 32'd0);

    // Asynchronous reset while requesting.
    habilita = 1'b1;
    espera_req();
    #2;
    reset = 1'b1;
    #1;
    check("arst_req", 32'(sensor_req), 32'd0);
    check("arst_a", 32'(somador_a), 32'd0);
    check("arst_b", 32'(somador_b), 32'd0);
    check("arst_media", 32'(media), 32'd0);
    check("arst_bomba", 32'(bomba), 32'd0);
    check("arst_erro", 32'(erro), 32'd0);
    check("arst_mv", 32'(media_valida), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    tick();
    check("arst_state_idle", 32'(sensor_req), 32'd0);

    repeat (3) tick();
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
